stack_core: RTL and testbench
=============================

Name: stack_core

Overview:
- LIFO storage engine behind the TT06 stack top level.
- Consumes the level-type push/pop pin requests decoded from ui_in[7]/ui_in[6] and the 8-bit data operand.
- Performs one stack operation per request and reports completion on instructionDone (uo_out[7]) with a one-cycle pulse.
- Also exposes the top-of-stack value and status flags for the remaining uo_out and uio pins.

Parameters:
- DEPTH, 8, number of stack entries; power of two, minimum 2.
- WIDTH, 8, data bits per entry.
- SYNC_STAGES, 2, synchronizer flops on the push/pop pin inputs; minimum 2.

Ports:
- clk  input  1  design clock.
- rst  input  1  asynchronous active-high reset; the top level drives it with ~rst_n.
- push  input  1  async level request from pin; a rising edge requests a push.
- pop  input  1  async level request from pin; a rising edge requests a pop.
- data_in  input  WIDTH  push operand; sampled in the EXEC cycle, so it must be stable from the push edge until instructionDone.
- data_out  output  WIDTH  registered current top of stack; 0 when empty.
- instruction_done  output  1  one-cycle pulse when an operation completes (accepted or rejected).
- count  output  $clog2(DEPTH)+1  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- error  output  1  sticky: last completed operation was rejected.

Behaviour:
- Reset (async assert, sync release via plain flops): state=IDLE, count=0, data_out=0, instruction_done=0, error=0, all sync/edge flops=0. Memory contents are not reset.
- Input path: push and pop each pass through SYNC_STAGES flops, then an edge register. The request is push_rise = push_s & ~push_q; pop_rise is formed the same way.
- FSM states and transitions:
  - IDLE: on any rise, latch op (PUSH, POP, or BOTH) and go to EXEC. Rises arriving outside IDLE are dropped; there is no queueing.
  - EXEC, one cycle:
    - PUSH with !full: mem[count]<=data_in, count+1, data_out<=data_in, error<=0.
    - PUSH with full: no write, error<=1.
    - POP with !empty: count-1; data_out<=mem[count-2] if count>=2, else 0; error<=0.
    - POP with empty: error<=1, data_out stays 0.
    - BOTH: replace top. If !empty, mem[count-1]<=data_in and data_out<=data_in, count unchanged, error<=0. If empty, behaves as PUSH.
    - Always go to DONE.
  - DONE: instruction_done=1 for exactly this cycle, then go to IDLE.
- Latency: the rise is detected in cycle N (edge register updates), EXEC is N+1, instruction_done and the updated data_out/count/flags are visible N+2. Pin-to-done latency is SYNC_STAGES+2 cycles.
- Throughput: at most one operation per 3 cycles. A level held high produces exactly one operation.
- Width rules: count never wraps; over- and underflow are rejected, never wrapped. Pointer arithmetic is done in $clog2(DEPTH)+1 bits.
- Reset mid-operation (EXEC or DONE): everything returns to reset values, no instruction_done pulse is emitted, and the partial write is irrelevant because count=0.
- empty and full are combinational from count. All other outputs are registered.

Decomposition:
- Package stack_pkg:
  - op enum (OP_NONE, OP_PUSH, OP_POP, OP_REPLACE).
  - FSM state enum (S_IDLE, S_EXEC, S_DONE).
  - Default DEPTH/WIDTH constants.
- One sub-module, pin_edge_sync (synchronizer chain plus rising-edge detect), instantiated twice.
- Memory is an inferred register array inside stack_core.

Test Plan:
- Reset, then pulse push with data_in=0xA5 → instruction_done one cycle at pin-rise+4, data_out=0xA5, count=1, empty=0, error=0.
- Push 0x11,0x22,0x33, then pop twice → after each pop data_out=0x22 then 0x11; count=3→2→1; each op yields exactly one done pulse.
- Fill DEPTH=8 entries (0x01..0x08), push 0x99 → full=1, error=1, count=8, data_out=0x08. A following pop clears error, data_out=0x07.
- Pop on empty → done pulse, error=1, data_out=0, count=0. Hold pop high 20 cycles → only one done pulse.
- Stack holds 0x10,0x20; raise push and pop in the same cycle with data_in=0x77 → count=2, data_out=0x77. A pop then gives data_out=0x10.
- Assert rst during EXEC of a push onto count=3 → immediately count=0, data_out=0, error=0, no done pulse. Next push 0x5A gives count=1, data_out=0x5A.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and default sizing for the LIFO stack engine.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DEF_DEPTH       = 8;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Simultaneous push and pop edges collapse into a single top-of-stack replace.
    function automatic op_e decode_op(input logic push_rise, input logic pop_rise);
        if (push_rise && pop_rise) return OP_REPLACE;
        if (push_rise)             return OP_PUSH;
        if (pop_rise)              return OP_POP;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/pin_edge_sync.sv
// Synchronizes an asynchronous pin level and emits a one-cycle pulse on its rising edge.
module pin_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_q    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_q    <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_q;

endmodule

// File: rtl/stack_core.sv
// LIFO storage engine: one push/pop/replace per pin edge, reported by a one-cycle done pulse.
module stack_core
    import stack_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     instruction_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic             w_push_rise;
    logic             w_pop_rise;
    state_e           r_state;
    op_e              r_op;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_done;
    logic             r_error;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_idx_top;
    logic [AW-1:0]    w_idx_below;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_push_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (push),
        .o_rise (w_push_rise)
    );

    pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pop_sync (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (pop),
        .o_rise (w_pop_rise)
    );

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_idx_top   = AW'(r_count - CW'(1));
    assign w_idx_below = AW'(r_count - CW'(2));

    // A replace on an empty stack degenerates into a push at slot 0.
    assign w_wr_en  = (r_state == S_EXEC) &&
                      (((r_op == OP_PUSH) && !w_full) || (r_op == OP_REPLACE));
    assign w_wr_idx = ((r_op == OP_REPLACE) && !w_empty) ? w_idx_top : r_count[AW-1:0];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NONE;
            r_count    <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_push_rise || w_pop_rise) begin
                        r_op    <= decode_op(w_push_rise, w_pop_rise);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    case (r_op)
                        OP_PUSH: begin
                            if (w_full) begin
                                r_error <= 1'b1;
                            end else begin
                                r_count    <= r_count + CW'(1);
                                r_data_out <= data_in;
                                r_error    <= 1'b0;
                            end
                        end
                        OP_POP: begin
                            if (w_empty) begin
                                r_error <= 1'b1;
                            end else begin
                                r_count    <= r_count - CW'(1);
                                r_data_out <= (r_count >= CW'(2)) ? r_mem[w_idx_below] : '0;
                                r_error    <= 1'b0;
                            end
                        end
                        OP_REPLACE: begin
                            if (w_empty) begin
                                r_count <= r_count + CW'(1);
                            end
                            r_data_out <= data_in;
                            r_error    <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out         = r_data_out;
    assign instruction_done = r_done;
    assign count            = r_count;
    assign empty            = w_empty;
    assign full             = w_full;
    assign error            = r_error;

endmodule

// File: tb/tb_stack_core.sv
// Scenario bench for stack_core with a queue-based LIFO reference model.
module tb_stack_core;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             instruction_done;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             error;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] mq[$];
    bit               merr;

    stack_core #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .push             (push),
        .pop              (pop),
        .data_in          (data_in),
        .data_out         (data_out),
        .instruction_done (instruction_done),
        .count            (count),
        .empty            (empty),
        .full             (full),
        .error            (error)
    );

    always #5 clk = ~clk;

    // Reference LIFO: operations expressed directly on a queue.
    function automatic void model_apply(input bit p, input bit q, input logic [WIDTH-1:0] d);
        if (p && q && mq.size() > 0) begin
            mq[mq.size()-1] = d;
            merr = 1'b0;
        end else if (p) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(d);
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
        end else if (q) begin
            if (mq.size() > 0) begin
                void'(mq.pop_back());
                merr = 1'b0;
            end else begin
                merr = 1'b1;
            end
        end
    endfunction

    function automatic logic [WIDTH-1:0] model_top();
        return (mq.size() > 0) ? mq[mq.size()-1] : '0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        merr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Raise the pins, measure edges until done, verify the pulse width, release and settle.
    task automatic do_op(input bit p, input bit q, input logic [WIDTH-1:0] d,
                         output int lat, output bit one_pulse);
        @(negedge clk);
        data_in = d;
        push = p;
        pop = q;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (instruction_done) begin
                lat = c;
                break;
            end
        end
        @(posedge clk);
        #1;
        one_pulse = (lat > 0) && !instruction_done;
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        repeat (5) @(negedge clk);
        model_apply(p, q, d);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({count, data_out, instruction_done, empty, full, error} !== {4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got cnt=%0d dout=%h done=%b e=%b f=%b err=%b, want 0 00 0 1 0 0",
                     count, data_out, instruction_done, empty, full, error);
        end
    endtask

    task automatic test_first_push();
        int lat;
        bit one;
        do_op(1, 0, 8'hA5, lat, one);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL push_latency: got %0d cycles, want 4", lat);
        end
        n_cmp++;
        if (!one) begin
            n_err++;
            $display("FAIL push_done_width: pulse not exactly one cycle (got 0, want 1)");
        end
        n_cmp++;
        if ({data_out, count, empty, error} !== {8'hA5, 4'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL first_push: got dout=%h cnt=%0d e=%b err=%b, want a5 1 0 0",
                     data_out, count, empty, error);
        end
    endtask

    task automatic test_push_pop();
        int lat;
        bit one;
        logic [WIDTH-1:0] exp_d [2] = '{8'h22, 8'h11};
        do_reset();
        do_op(1, 0, 8'h11, lat, one);
        do_op(1, 0, 8'h22, lat, one);
        do_op(1, 0, 8'h33, lat, one);
        n_cmp++;
        if (count !== 4'd3) begin
            n_err++;
            $display("FAIL three_push_count: got %0d, want 3", count);
        end
        for (int i = 0; i < 2; i++) begin
            do_op(0, 1, 8'h00, lat, one);
            n_cmp++;
            if ({data_out, count, lat[3:0], one} !== {exp_d[i], 4'(2 - i), 4'd4, 1'b1}) begin
                n_err++;
                $display("FAIL pop_%0d: got dout=%h cnt=%0d lat=%0d one=%b, want %h %0d 4 1",
                         i, data_out, count, lat, one, exp_d[i], 2 - i);
            end
        end
    endtask

    task automatic test_full();
        int lat;
        bit one;
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(1, 0, 8'(i), lat, one);
        end
        do_op(1, 0, 8'h99, lat, one);
        n_cmp++;
        if ({full, error, count, data_out, one} !== {1'b1, 1'b1, 4'd8, 8'h08, 1'b1}) begin
            n_err++;
            $display("FAIL push_full: got f=%b err=%b cnt=%0d dout=%h one=%b, want 1 1 8 08 1",
                     full, error, count, data_out, one);
        end
        do_op(0, 1, 8'h00, lat, one);
        n_cmp++;
        if ({full, error, count, data_out} !== {1'b0, 1'b0, 4'd7, 8'h07}) begin
            n_err++;
            $display("FAIL pop_after_full: got f=%b err=%b cnt=%0d dout=%h, want 0 0 7 07",
                     full, error, count, data_out);
        end
    endtask

    task automatic test_pop_empty_hold();
        int lat;
        bit one;
        int pulses;
        do_reset();
        do_op(0, 1, 8'h00, lat, one);
        n_cmp++;
        if ({error, data_out, count, one} !== {1'b1, 8'h00, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL pop_empty: got err=%b dout=%h cnt=%0d one=%b, want 1 00 0 1",
                     error, data_out, count, one);
        end
        pulses = 0;
        @(negedge clk);
        pop = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instruction_done) pulses++;
        end
        pop = 1'b0;
        repeat (6) @(negedge clk);
        if (instruction_done) pulses++;
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL held_pop_pulses: got %0d, want 1", pulses);
        end
    endtask

    task automatic test_replace();
        int lat;
        bit one;
        do_reset();
        do_op(1, 0, 8'h10, lat, one);
        do_op(1, 0, 8'h20, lat, one);
        do_op(1, 1, 8'h77, lat, one);
        n_cmp++;
        if ({count, data_out, error, one} !== {4'd2, 8'h77, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL replace: got cnt=%0d dout=%h err=%b one=%b, want 2 77 0 1",
                     count, data_out, error, one);
        end
        do_op(0, 1, 8'h00, lat, one);
        n_cmp++;
        if ({count, data_out} !== {4'd1, 8'h10}) begin
            n_err++;
            $display("FAIL pop_after_replace: got cnt=%0d dout=%h, want 1 10", count, data_out);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit one;
        int pulses;
        do_reset();
        do_op(1, 0, 8'h01, lat, one);
        do_op(1, 0, 8'h02, lat, one);
        do_op(1, 0, 8'h03, lat, one);
        @(negedge clk);
        data_in = 8'hEE;
        push = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({count, data_out, error, instruction_done} !== {4'd0, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_in_exec: got cnt=%0d dout=%h err=%b done=%b, want 0 00 0 0",
                     count, data_out, error, instruction_done);
        end
        pulses = 0;
        push = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (instruction_done) pulses++;
        end
        rst = 1'b0;
        mq.delete();
        merr = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (instruction_done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d pulses, want 0", pulses);
        end
        do_op(1, 0, 8'h5A, lat, one);
        n_cmp++;
        if ({count, data_out} !== {4'd1, 8'h5A}) begin
            n_err++;
            $display("FAIL push_after_reset: got cnt=%0d dout=%h, want 1 5a", count, data_out);
        end
    endtask

    task automatic test_random();
        int lat;
        bit one;
        bit p;
        bit q;
        int r;
        logic [WIDTH-1:0] d;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            p = (r < 5) || (r >= 8);
            q = (r >= 5);
            d = WIDTH'($urandom);
            do_op(p, q, d, lat, one);
            n_cmp++;
            if (lat !== 4 || !one || data_out !== model_top() || count !== 4'(mq.size()) ||
                empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || error !== merr) begin
                n_err++;
                $display("FAIL random_op_%0d: got lat=%0d one=%b dout=%h cnt=%0d e=%b f=%b err=%b, want 4 1 %h %0d %b %b %b",
                         i, lat, one, data_out, count, empty, full, error, model_top(), mq.size(),
                         mq.size() == 0, mq.size() == DEPTH, merr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_push_pop();
        test_full();
        test_pop_empty_hold();
        test_replace();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
